sw_host_master: RTL

SW_HOST_MASTER -- requirements
Module: sw_host_master

---
 rtl/switch_pkg.sv | 38 +++
 rtl/host_cmd_fifo.sv | 52 +++++
 rtl/sw_host_master.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/switch_pkg.sv
// Shared encodings for the switch register host master: command ops, engine states, register map.
// The GAP engine state exists only when HOST_POLL_EN is defined.
package switch_pkg;

   typedef enum logic [1:0] {
      OP_WR   = 2'b00,
      OP_RD   = 2'b01,
      OP_POLL = 2'b10,
      OP_RSVD = 2'b11
   } op_e;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_WR     = 3'd1,
      ST_RD     = 3'd2,
      ST_RD_CAP = 3'd3,
`ifdef HOST_POLL_EN
      ST_RSP    = 3'd4,
      ST_GAP    = 3'd5
`else
      ST_RSP    = 3'd4
`endif
   } state_e;

   localparam int CMD_W = 37;

   localparam logic [2:0] REG_CTRL   = 3'd0;
   localparam logic [2:0] REG_STATUS = 3'd1;
   localparam logic [2:0] REG_DATA   = 3'd2;
   localparam logic [2:0] REG_POLL   = 3'd3;

   // FIFO entry layout: {op[36:35], addr[34:32], data[31:0]}
   function automatic logic [CMD_W-1:0] pack_cmd(input op_e op, input logic [2:0] addr,
                                                 input logic [31:0] data);
      return {op, addr, data};
   endfunction

endpackage

// File: rtl/host_cmd_fifo.sv
// Command FIFO for sw_host_master: power-of-two depth, registered count, show-ahead head output.
module host_cmd_fifo #(
   parameter int WIDTH = 37,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_din,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_dout,
   output logic             o_empty,
   output logic             o_full
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_count;
   logic             w_do_push;
   logic             w_do_pop;

   assign o_empty   = (r_count == '0);
   assign o_full    = (r_count == (AW+1)'(DEPTH));
   assign w_do_push = i_push && !o_full;
   assign w_do_pop  = i_pop && !o_empty;
   assign o_dout    = r_mem[r_rd_ptr];

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + (AW+1)'(1);
            2'b01:   r_count <= r_count - (AW+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wr_ptr] <= i_din;
   end

endmodule

// File: rtl/sw_host_master.sv
// Host-side bus master for the switch register slave: queued write/read/poll commands, one bus op at a time.
// Define HOST_POLL_EN to enable repeated polling on bit 31 with a GAP cycle between reads.
module sw_host_master
   import switch_pkg::*;
#(
   parameter int CMD_DEPTH = 4,
   parameter int POLL_MAX  = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [1:0]  cmd_op,
   input  logic [2:0]  cmd_addr,
   input  logic [31:0] cmd_data,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_data,
   output logic        rsp_timeout,
   output logic        chipselect,
   output logic        write,
   output logic        read,
   output logic [2:0]  address,
   output logic [31:0] writedata,
   input  logic [31:0] readdata,
   output logic        busy,
   output logic [2:0]  dbg_state
);

   if (CMD_DEPTH < 2 || (CMD_DEPTH & (CMD_DEPTH - 1)) != 0 || POLL_MAX < 1) begin : g_bad_cfg
      $error("sw_host_master: CMD_DEPTH must be a power of two >= 2 and POLL_MAX >= 1");
   end

   state_e            r_state;
   logic              r_rdy;
   logic              r_cs;
   logic              r_wr;
   logic              r_rd;
   logic [2:0]        r_addr;
   logic [31:0]       r_wdata;
   logic              r_rsp_valid;
   logic [31:0]       r_rsp_data;
   logic              w_empty;
   logic              w_full;
   logic              w_push;
   logic              w_pop;
   logic [CMD_W-1:0]  w_head;
   op_e               w_op;

   assign w_push = cmd_valid && cmd_ready;
   assign w_pop  = (r_state == ST_IDLE) && !w_empty;
   assign w_op   = op_e'(w_head[36:35]);

   host_cmd_fifo #(.WIDTH(CMD_W), .DEPTH(CMD_DEPTH)) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .i_push  (w_push),
      .i_din   (pack_cmd(op_e'(cmd_op), cmd_addr, cmd_data)),
      .i_pop   (w_pop),
      .o_dout  (w_head),
      .o_empty (w_empty),
      .o_full  (w_full)
   );

`ifdef HOST_POLL_EN
   localparam int PCW = $clog2(POLL_MAX + 1);
   logic           r_poll;
   logic [2:0]     r_poll_addr;
   logic [PCW-1:0] r_poll_cnt;
   logic           r_timeout;
   assign rsp_timeout = r_timeout;
`else
   assign rsp_timeout = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_rdy       <= 1'b0;
         r_cs        <= 1'b0;
         r_wr        <= 1'b0;
         r_rd        <= 1'b0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_rsp_valid <= 1'b0;
         r_rsp_data  <= '0;
`ifdef HOST_POLL_EN
         r_poll      <= 1'b0;
         r_poll_addr <= '0;
         r_poll_cnt  <= '0;
         r_timeout   <= 1'b0;
`endif
      end else begin
         r_rdy <= 1'b1;
         case (r_state)
            ST_IDLE: begin
               // Strobes are registered on the pop edge so they line up with the WR/RD state.
               if (!w_empty) begin
                  case (w_op)
                     OP_WR: begin
                        r_cs    <= 1'b1;
                        r_wr    <= 1'b1;
                        r_addr  <= w_head[34:32];
                        r_wdata <= w_head[31:0];
                        r_state <= ST_WR;
                     end
                     OP_RD, OP_POLL: begin
                        r_cs    <= 1'b1;
                        r_rd    <= 1'b1;
                        r_addr  <= w_head[34:32];
                        r_state <= ST_RD;
`ifdef HOST_POLL_EN
                        r_poll      <= (w_op == OP_POLL);
                        r_poll_addr <= w_head[34:32];
                        r_poll_cnt  <= PCW'(1);
`endif
                     end
                     default: r_state <= ST_IDLE;
                  endcase
               end
            end
            ST_WR: begin
               r_cs    <= 1'b0;
               r_wr    <= 1'b0;
               r_addr  <= '0;
               r_wdata <= '0;
               r_state <= ST_IDLE;
            end
            ST_RD: begin
               r_cs    <= 1'b0;
               r_rd    <= 1'b0;
               r_addr  <= '0;
               r_state <= ST_RD_CAP;
            end
            ST_RD_CAP: begin
               r_rsp_data <= readdata;
`ifdef HOST_POLL_EN
               if (r_poll && !readdata[31] && r_poll_cnt != PCW'(POLL_MAX)) begin
                  r_state <= ST_GAP;
               end else begin
                  r_rsp_valid <= 1'b1;
                  r_timeout   <= r_poll && !readdata[31];
                  r_state     <= ST_RSP;
               end
`else
               r_rsp_valid <= 1'b1;
               r_state     <= ST_RSP;
`endif
            end
            ST_RSP: begin
               if (rsp_ready) begin
                  r_rsp_valid <= 1'b0;
                  r_rsp_data  <= '0;
`ifdef HOST_POLL_EN
                  r_timeout   <= 1'b0;
`endif
                  r_state     <= ST_IDLE;
               end
            end
`ifdef HOST_POLL_EN
            ST_GAP: begin
               r_cs       <= 1'b1;
               r_rd       <= 1'b1;
               r_addr     <= r_poll_addr;
               r_poll_cnt <= r_poll_cnt + PCW'(1);
               r_state    <= ST_RD;
            end
`endif
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign cmd_ready  = r_rdy && !w_full;
   assign rsp_valid  = r_rsp_valid;
   assign rsp_data   = r_rsp_data;
   assign chipselect = r_cs;
   assign write      = r_wr;
   assign read       = r_rd;
   assign address    = r_addr;
   assign writedata  = r_wdata;
   assign busy       = !w_empty || (r_state != ST_IDLE);
   assign dbg_state  = r_state;

endmodule
